// File: rtl/tree_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tree_sum_accumulator                                          |
// | Brief    : Collects BLOCK_LEN adder-tree sums; reports total, mean, max. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

module tree_sum_accumulator #(
    parameter int unsigned IN_W     = 10,
    parameter int unsigned LOG2_LEN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IN_W+LOG2_LEN-1:0] out_total,
    output logic [IN_W-1:0]          out_mean,
    output logic [IN_W-1:0]          out_max
);

    localparam int unsigned BLOCK_LEN = 2 ** LOG2_LEN;
    localparam int unsigned c_acc_w   = IN_W + LOG2_LEN;
    localparam logic [LOG2_LEN-1:0] c_cnt_last = LOG2_LEN'(BLOCK_LEN - 1);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_acc_w-1:0]   r_acc;
    logic [IN_W-1:0]      r_max;
    logic [LOG2_LEN-1:0]  r_cnt;
    logic [c_acc_w-1:0]   r_total;
    logic [IN_W-1:0]      r_mean;
    logic [IN_W-1:0]      r_max_out;

    logic                 w_accept;
    logic                 w_last;
    logic [c_acc_w-1:0]   w_sum;
    logic [IN_W-1:0]      w_max_upd;

    // Accumulator carries LOG2_LEN guard bits, so this add never wraps.
    assign w_sum     = r_acc + c_acc_w'(in_sum);
    assign w_max_upd = (in_sum > r_max) ? in_sum : r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_accept = in_valid;
                w_last   = in_valid && (r_cnt == c_cnt_last);
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
        // clear aborts the block and discards any pending result
        if (clear) begin
            w_state_nxt = ST_ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_max     <= '0;
            r_cnt     <= '0;
            r_total   <= '0;
            r_mean    <= '0;
            r_max_out <= '0;
        end else if (clear) begin
            r_acc <= '0;
            r_max <= '0;
            r_cnt <= '0;
        end else if (w_last) begin
            r_total   <= w_sum;
            r_mean    <= w_sum[c_acc_w-1:LOG2_LEN];
            r_max_out <= w_max_upd;
            r_acc     <= '0;
            r_max     <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_max <= w_max_upd;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Handshake outputs depend on the state register alone.
    assign in_ready  = (r_state == ST_ACCUM);
    assign out_valid = (r_state == ST_HOLD);
    assign out_total = r_total;
    assign out_mean  = r_mean;
    assign out_max   = r_max_out;

endmodule

`default_nettype wire
